// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream and instruction-memory write bundle for the program loader
//
// Purpose: groups the byte source handshake, the instruction memory write port
// and the boot status flags so the loader and its byte source share one port.
// Signals:
//   byte_in[7:0]        stream byte from the source
//   byte_valid          byte_in holds a valid byte
//   byte_ready          loader accepts a byte this cycle
//   imem_write_enable   single-cycle write strobe to instruction memory
//   imem_address        write address (ADDR_WIDTH bits)
//   imem_data           write data (WORD_WIDTH bits)
//   cpu_hold            keeps the CPU in reset while high
//   load_done           image loaded and verified (sticky until reset)
//   error               length or checksum failure (sticky until reset)
// Modports: master = byte source / observer, slave = loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  imem_write_enable;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [WORD_WIDTH-1:0] imem_data;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  error;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_write_enable, imem_address, imem_data,
    input  cpu_hold, load_done, error
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_write_enable, imem_address, imem_data,
    output cpu_hold, load_done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time byte stream loader into instruction memory
//
// Purpose: accepts a stream of LEN_HI, LEN_LO, N big-endian 16-bit words and an
// XOR checksum byte; writes each word to instruction memory and releases the
// CPU (cpu_hold low) only once the whole image is written and the checksum
// matches.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    program_loader_if.slave (byte handshake, imem write port, status)
module program_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  program_loader_if.slave     bus
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECKSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  // One bit wider than the address so a full 2^ADDR_WIDTH image does not wrap.
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  logic                  ready;
  logic                  xfer;
  logic [15:0]           len_full;
  logic [ADDR_WIDTH:0]   idx_next;

  assign ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO)  ||
                 (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                 (state_q == S_CHECKSUM);
  assign xfer     = bus.byte_valid && ready;
  assign len_full = {len_q[15:8], bus.byte_in};
  assign idx_next = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.byte_in;
          csum_d      = csum_q ^ bus.byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d  = len_full;
          csum_d = csum_q ^ bus.byte_in;
          if ({16'd0, len_full} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECKSUM;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          data_d[WORD_WIDTH-1 -: 8] = bus.byte_in;
          csum_d                    = csum_q ^ bus.byte_in;
          state_d                   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          data_d[7:0] = bus.byte_in;
          csum_d      = csum_q ^ bus.byte_in;
          // Address is captured here so it stays stable after the index moves on.
          addr_d      = idx_q[ADDR_WIDTH-1:0];
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d = idx_next;
        // len_q is known to be <= 2^ADDR_WIDTH here, so its upper bits are zero.
        if (idx_next == len_q[ADDR_WIDTH:0]) begin
          state_d = S_CHECKSUM;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_CHECKSUM: begin
        if (xfer) begin
          state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  assign bus.byte_ready        = ready;
  assign bus.imem_write_enable = (state_q == S_WRITE);
  assign bus.imem_address      = addr_q;
  assign bus.imem_data         = data_q;
  assign bus.load_done         = (state_q == S_DONE);
  assign bus.error             = (state_q == S_ERROR);
  assign bus.cpu_hold          = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) bus ();

  program_loader #(.ADDR_WIDTH(12), .WORD_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          writes_seen;
  logic [11:0] last_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Image model: parses the stream by its format rules into the list of
  // expected writes and the expected final outcome.
  task automatic load_model(input logic [7:0] s[$], output bit e_done, output bit e_err);
    int n;
    logic [7:0] x;
    n = {s[0], s[1]};
    if (n > 4096) begin
      e_done = 1'b0;
      e_err  = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(i[11:0]);
      exp_data_q.push_back({s[2 + 2 * i], s[3 + 2 * i]});
    end
    x = 8'h00;
    for (int k = 0; k < 2 + 2 * n; k++) x = x ^ s[k];
    e_done = (x == s[2 + 2 * n]);
    e_err  = !e_done;
  endtask

  // Compare process: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (!reset) begin
      check("hold_vs_done", bus.cpu_hold, !bus.load_done);
      if (bus.imem_write_enable) begin
        check("ready_low_in_write", bus.byte_ready, 0);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.imem_address, bus.imem_data);
        end else begin
          check("write_addr", bus.imem_address, exp_addr_q.pop_front());
          check("write_data", bus.imem_data, exp_data_q.pop_front());
        end
        writes_seen++;
        last_addr = bus.imem_address;
      end
    end
  end

  task automatic send(input logic [7:0] s[$], input bit gaps);
    int w;
    int g;
    foreach (s[k]) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          bus.byte_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus.byte_in    = s[k];
      bus.byte_valid = 1'b1;
      w = 0;
      while (!bus.byte_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!bus.byte_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL handshake_timeout byte %0d: got byte_ready 0 expected 1", k);
        return;
      end
    end
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    writes_seen = 0;
  endtask

  task automatic run_image(input string name, input logic [7:0] s[$], input bit gaps,
                           input bit with_reset, input int n_writes_lit,
                           input bit done_lit, input logic [15:0] first_lit);
    bit ed;
    bit ee;
    if (with_reset) do_reset();
    exp_addr_q.delete();
    exp_data_q.delete();
    load_model(s, ed, ee);
    check({name, "_model_done"}, ed, done_lit);
    if (exp_data_q.size() > 0) check({name, "_model_first"}, exp_data_q[0], first_lit);
    send(s, gaps);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check({name, "_load_done"}, bus.load_done, ed);
    check({name, "_error"}, bus.error, ee);
    check({name, "_cpu_hold"}, bus.cpu_hold, !ed);
    check({name, "_byte_ready"}, bus.byte_ready, 0);
    check({name, "_write_count"}, writes_seen, n_writes_lit);
    check({name, "_pending_writes"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    logic [15:0] w;

    reset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    #12;
    check("rst_we", bus.imem_write_enable, 0);
    check("rst_addr", bus.imem_address, 0);
    check("rst_data", bus.imem_data, 0);
    check("rst_hold", bus.cpu_hold, 1);
    check("rst_done", bus.load_done, 0);
    check("rst_error", bus.error, 0);
    check("rst_ready", bus.byte_ready, 1);

    // 1. normal load
    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h43};
    run_image("normal", s, 1'b0, 1'b1, 3, 1'b1, 16'h1234);

    // 2. bad checksum
    s = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h44};
    run_image("badsum", s, 1'b0, 1'b1, 3, 1'b0, 16'h1234);

    // 3. empty image
    s = '{8'h00, 8'h00, 8'h00};
    run_image("empty", s, 1'b0, 1'b1, 0, 1'b1, 16'h0000);

    // 4. oversize image, then later bytes must be refused
    s = '{8'h10, 8'h01};
    run_image("oversize", s, 1'b0, 1'b1, 0, 1'b0, 16'h0000);
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("oversize_refuse_ready", bus.byte_ready, 0);
      check("oversize_error_sticky", bus.error, 1);
    end
    bus.byte_valid = 1'b0;

    // 5. full image with gapped valid
    s = '{8'h10, 8'h00};
    for (int i = 0; i < 4096; i++) begin
      w = (i[15:0] * 16'd7) ^ 16'hC35A;
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
    end
    x = 8'h00;
    foreach (s[k]) x = x ^ s[k];
    s.push_back(x);
    run_image("full", s, 1'b1, 1'b1, 4096, 1'b1, 16'hC35A);
    check("full_last_addr", last_addr, 12'hFFF);

    // 6. reset mid-load, then a complete one-word image without another reset
    do_reset();
    s = '{8'h00, 8'h01, 8'hBE};
    send(s, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_we", bus.imem_write_enable, 0);
    check("midrst_addr", bus.imem_address, 0);
    check("midrst_data", bus.imem_data, 0);
    check("midrst_hold", bus.cpu_hold, 1);
    check("midrst_done", bus.load_done, 0);
    check("midrst_error", bus.error, 0);
    check("midrst_ready", bus.byte_ready, 1);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    writes_seen = 0;
    check("midrst_no_partial_write", exp_addr_q.size(), 0);
    s = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    run_image("after_reset", s, 1'b0, 1'b0, 1, 1'b1, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
